mem_port_arbiter: RTL and testbench

- Shares one single-port, 1-cycle-latency synchronous memory bank (RAM or ROM array) between the instruction-fetch port and the data port of the core.
- Grants at most one requester per cycle and drives the shared bank's address, enable and write controls.
- Raises the loser's wait, and steers registered read data back to whichever requester was granted in the previous cycle.
- Sits between the core's imem/dmem interfaces and the memory-region decoder.

---
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, 1-cycle-latency memory bank between fetch and data requesters.
// Optional build macro MEM_PORT_ARBITER_ROUND_ROBIN_EN selects alternating priority on contention.
module mem_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_wait,
  output logic [31:0]       i_rdata,
  output logic              i_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_byteen,
  output logic              d_wait,
  output logic [31:0]       d_rdata,
  output logic              d_rvalid,
  output logic              m_en,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_we,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_byteen,
  input  logic [31:0]       m_q
);

  typedef enum logic [1:0] {
    LG_NONE = 2'd0,
    LG_I    = 2'd1,
    LG_DR   = 2'd2
  } last_grant_t;

  logic        grant_i_s;
  logic        grant_d_s;
  last_grant_t last_grant_r;
  last_grant_t last_grant_next_s;

`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
  logic prio_i_r;  // 1: fetch wins the next contended cycle

  // Grant selection with alternating priority under contention; no grant while in reset.
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (reset_n == 1'b0) begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end else if (i_req && d_req) begin
      grant_i_s = prio_i_r;
      grant_d_s = ~prio_i_r;
    end else begin
      grant_i_s = i_req;
      grant_d_s = d_req;
    end
  end

  // Priority flag flips after every contended grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_i_r <= 1'b0;
    end else if (i_req && d_req) begin
      prio_i_r <= ~prio_i_r;
    end else begin
      prio_i_r <= prio_i_r;
    end
  end
`else
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
  logic [7:0] starve_cnt_r;

  // Grant selection: data first, unless fetch has been denied STARVE_MAX cycles in a row.
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (reset_n == 1'b0) begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end else if (i_req && d_req) begin
      grant_i_s = (starve_cnt_r == STARVE_LIM);
      grant_d_s = (starve_cnt_r != STARVE_LIM);
    end else begin
      grant_i_s = i_req;
      grant_d_s = d_req;
    end
  end

  // Saturating count of consecutive denied fetch cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_r <= 8'd0;
    end else if (i_req && !grant_i_s) begin
      starve_cnt_r <= (starve_cnt_r == 8'hFF) ? starve_cnt_r : starve_cnt_r + 8'd1;
    end else begin
      starve_cnt_r <= 8'd0;
    end
  end
`endif

  assign i_wait = i_req & ~grant_i_s;
  assign d_wait = d_req & ~grant_d_s;

  // Bank control mux and next return-owner from the current winner.
  always_comb begin
    m_en              = 1'b0;
    m_addr            = '0;
    m_we              = 1'b0;
    m_wdata           = 32'h0000_0000;
    m_byteen          = 4'b0000;
    last_grant_next_s = LG_NONE;
    case ({grant_i_s, grant_d_s})
      2'b10: begin
        m_en              = 1'b1;
        m_addr            = i_addr;
        m_byteen          = 4'b1111;
        last_grant_next_s = LG_I;
      end
      2'b01: begin
        m_en              = 1'b1;
        m_addr            = d_addr;
        m_we              = d_we;
        m_wdata           = d_wdata;
        m_byteen          = d_byteen;
        last_grant_next_s = d_we ? LG_NONE : LG_DR;
      end
      default: begin
        m_en              = 1'b0;
        last_grant_next_s = LG_NONE;
      end
    endcase
  end

  // Remembers which requester owns the bank output on the next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_r <= LG_NONE;
    end else begin
      last_grant_r <= last_grant_next_s;
    end
  end

  // Steer bank read data to the previous cycle's reader; zero otherwise.
  always_comb begin
    i_rvalid = 1'b0;
    i_rdata  = 32'h0000_0000;
    d_rvalid = 1'b0;
    d_rdata  = 32'h0000_0000;
    case (last_grant_r)
      LG_I: begin
        i_rvalid = 1'b1;
        i_rdata  = m_q;
      end
      LG_DR: begin
        d_rvalid = 1'b1;
        d_rdata  = m_q;
      end
      default: begin
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default build, or round-robin build when
// MEM_PORT_ARBITER_ROUND_ROBIN_EN is defined).
module tb_mem_port_arbiter;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_wait;
  logic [31:0]       i_rdata;
  logic              i_rvalid;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_byteen;
  logic              d_wait;
  logic [31:0]       d_rdata;
  logic              d_rvalid;
  logic              m_en;
  logic [ADDR_W-1:0] m_addr;
  logic              m_we;
  logic [31:0]       m_wdata;
  logic [3:0]        m_byteen;
  logic [31:0]       m_q;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_wait(i_wait), .i_rdata(i_rdata), .i_rvalid(i_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_byteen(d_byteen),
    .d_wait(d_wait), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .m_en(m_en), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_byteen(m_byteen),
    .m_q(m_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = 32'h0; d_byteen = 4'b0000;
  endtask

  initial begin
    idle();
    m_q     = 32'h0;
    reset_n = 1'b0;

    // Reset: waits follow requests, bank idle, no returns.
    i_req = 1'b1; i_addr = 14'h0011; d_req = 1'b1; d_addr = 14'h0022;
    #2;
    chk("rst_i_wait", 32'(i_wait), 32'd1);
    chk("rst_d_wait", 32'(d_wait), 32'd1);
    chk("rst_m_en", 32'(m_en), 32'd0);
    chk("rst_m_addr", 32'(m_addr), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_byteen", 32'(m_byteen), 32'd0);
    chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    next_cycle();
    idle();
    reset_n = 1'b1;
    next_cycle();

    // Fetch only, 3 cycles at 0x0010.
    for (int k = 0; k < 3; k++) begin
      i_req = 1'b1; i_addr = 14'h0010;
      m_q = 32'h1111_0000 + 32'(k);
      #1;
      chk("fo_i_wait", 32'(i_wait), 32'd0);
      chk("fo_m_en", 32'(m_en), 32'd1);
      chk("fo_m_addr", 32'(m_addr), 32'h0010);
      chk("fo_m_we", 32'(m_we), 32'd0);
      chk("fo_m_byteen", 32'(m_byteen), 32'hF);
      chk("fo_m_wdata", m_wdata, 32'h0);
      chk("fo_i_rvalid", 32'(i_rvalid), (k == 0) ? 32'd0 : 32'd1);
      chk("fo_i_rdata", i_rdata, (k == 0) ? 32'h0 : 32'h1111_0000 + 32'(k));
      chk("fo_d_rvalid", 32'(d_rvalid), 32'd0);
      next_cycle();
    end
    idle();
    m_q = 32'h1111_0003;
    #1;
    chk("fo_tail_i_rvalid", 32'(i_rvalid), 32'd1);
    chk("fo_tail_i_rdata", i_rdata, 32'h1111_0003);
    chk("fo_idle_m_en", 32'(m_en), 32'd0);
    next_cycle();
    #1;
    chk("fo_end_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("fo_end_i_rdata", i_rdata, 32'h0);

    // Data write contending with fetch: write wins.
    next_cycle();
    d_req = 1'b1; d_we = 1'b1; d_addr = 14'h0004; d_wdata = 32'hDEAD_BEEF; d_byteen = 4'b0010;
    i_req = 1'b1; i_addr = 14'h0010;
    #1;
    chk("wr_d_wait", 32'(d_wait), 32'd0);
    chk("wr_i_wait", 32'(i_wait), 32'd1);
    chk("wr_m_we", 32'(m_we), 32'd1);
    chk("wr_m_byteen", 32'(m_byteen), 32'h2);
    chk("wr_m_wdata", m_wdata, 32'hDEAD_BEEF);
    chk("wr_m_addr", 32'(m_addr), 32'h0004);
    next_cycle();
    idle();
    m_q = 32'h5555_AAAA;
    #1;
    chk("wr_no_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("wr_no_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("wr_no_d_rdata", d_rdata, 32'h0);

    // Back-to-back: data read 0x20 then fetch 0x30.
    next_cycle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 14'h0020; d_byteen = 4'b1111;
    #1;
    chk("b2b_m_addr0", 32'(m_addr), 32'h0020);
    chk("b2b_d_wait0", 32'(d_wait), 32'd0);
    next_cycle();
    idle();
    i_req = 1'b1; i_addr = 14'h0030; m_q = 32'hB0B0_0001;
    #1;
    chk("b2b_d_rvalid1", 32'(d_rvalid), 32'd1);
    chk("b2b_d_rdata1", d_rdata, 32'hB0B0_0001);
    chk("b2b_m_addr1", 32'(m_addr), 32'h0030);
    chk("b2b_i_rvalid1", 32'(i_rvalid), 32'd0);
    next_cycle();
    idle();
    m_q = 32'hC0C0_0002;
    #1;
    chk("b2b_i_rvalid2", 32'(i_rvalid), 32'd1);
    chk("b2b_i_rdata2", i_rdata, 32'hC0C0_0002);
    chk("b2b_d_rvalid2", 32'(d_rvalid), 32'd0);

    // Reset asserted with a data read outstanding.
    next_cycle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 14'h0044; d_byteen = 4'b1111;
    #1;
    chk("rmr_m_en_pre", 32'(m_en), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rmr_m_en", 32'(m_en), 32'd0);
    chk("rmr_m_addr", 32'(m_addr), 32'd0);
    chk("rmr_m_byteen", 32'(m_byteen), 32'd0);
    chk("rmr_d_wait", 32'(d_wait), 32'd1);
    next_cycle();
    chk("rmr_d_rvalid", 32'(d_rvalid), 32'd0);
    idle();
    reset_n = 1'b1;
    next_cycle();
    chk("rmr_post_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rmr_post_i_rvalid", 32'(i_rvalid), 32'd0);

`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
    // Round-robin: continuous read contention gives D, I, D, I.
    for (int k = 0; k < 4; k++) begin
      d_req = 1'b1; d_we = 1'b0; d_addr = 14'h0040; d_byteen = 4'b1111;
      i_req = 1'b1; i_addr = 14'h0050;
      m_q = 32'hA000_0000 + 32'(k);
      #1;
      chk("rr_i_wait", 32'(i_wait), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_d_wait", 32'(d_wait), (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr_m_addr", 32'(m_addr), (k % 2 == 0) ? 32'h0040 : 32'h0050);
      chk("rr_i_rvalid", 32'(i_rvalid), (k == 2) ? 32'd1 : 32'd0);
      chk("rr_d_rvalid", 32'(d_rvalid), (k == 1 || k == 3) ? 32'd1 : 32'd0);
      next_cycle();
    end
    idle();
    #1;
    chk("rr_tail_i_rvalid", 32'(i_rvalid), 32'd1);
`else
    // Starvation limit 3: data wins cycles 0-2, fetch wins cycle 3, data wins 4-5.
    for (int k = 0; k < 6; k++) begin
      d_req = 1'b1; d_we = 1'b0; d_addr = 14'h0040; d_byteen = 4'b1111;
      i_req = 1'b1; i_addr = 14'h0050;
      m_q = 32'hA000_0000 + 32'(k);
      #1;
      chk("st_i_wait", 32'(i_wait), (k == 3) ? 32'd0 : 32'd1);
      chk("st_d_wait", 32'(d_wait), (k == 3) ? 32'd1 : 32'd0);
      chk("st_m_addr", 32'(m_addr), (k == 3) ? 32'h0050 : 32'h0040);
      chk("st_i_rvalid", 32'(i_rvalid), (k == 4) ? 32'd1 : 32'd0);
      chk("st_d_rvalid", 32'(d_rvalid), (k == 1 || k == 2 || k == 3 || k == 5) ? 32'd1 : 32'd0);
      chk("st_d_rdata", d_rdata,
          (k == 1 || k == 2 || k == 3 || k == 5) ? 32'hA000_0000 + 32'(k) : 32'h0);
      next_cycle();
    end
    idle();
    m_q = 32'hA000_0006;
    #1;
    chk("st_tail_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("st_tail_d_rdata", d_rdata, 32'hA000_0006);
    chk("st_tail_i_rvalid", 32'(i_rvalid), 32'd0);
`endif

    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
